// File: rtl/systolic_ws_ctrl_if.sv
// Command and array-side signals of the weight-stationary systolic sequencer.
// The master side is the host/command logic; the slave side is the sequencer.
interface systolic_ws_ctrl_if #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned VEC_W = 8
);
  localparam int unsigned AW = $clog2(ROWS);

  logic             start;
  logic             reuse_weights;
  logic [VEC_W-1:0] num_vec;
  logic             abort;
  logic             busy;
  logic             done;
  logic             wt_rd_en;
  logic [AW-1:0]    wt_rd_addr;
  logic [ROWS-1:0]  load_row;
  logic             in_rd_en;
  logic [VEC_W-1:0] in_rd_addr;
  logic [ROWS-1:0]  row_valid;
  logic [COLS-1:0]  out_valid;

  modport master (
    output start, reuse_weights, num_vec, abort,
    input  busy, done, wt_rd_en, wt_rd_addr, load_row,
    input  in_rd_en, in_rd_addr, row_valid, out_valid
  );

  modport slave (
    input  start, reuse_weights, num_vec, abort,
    output busy, done, wt_rd_en, wt_rd_addr, load_row,
    output in_rd_en, in_rd_addr, row_valid, out_valid
  );
endinterface

// File: rtl/systolic_ws_ctrl.sv
// Job sequencer for a ROWS x COLS weight-stationary systolic array: weight load,
// activation streaming, per-row feeder skew and per-column output strobes.
module systolic_ws_ctrl #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned VEC_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_ws_ctrl_if.slave    bus
);
  localparam int unsigned AW = $clog2(ROWS);
  localparam int unsigned DW = $clog2(ROWS + COLS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [VEC_W-1:0] n_last;     // num_vec - 1, so the last address compares directly
  logic [DW-1:0]    drain_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      n_last         <= '0;
      drain_cnt      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.wt_rd_en   <= 1'b0;
      bus.wt_rd_addr <= '0;
      bus.load_row   <= '0;
      bus.in_rd_en   <= 1'b0;
      bus.in_rd_addr <= '0;
      bus.row_valid  <= '0;
      bus.out_valid  <= '0;
    end else if (bus.abort) begin
      state          <= IDLE;
      n_last         <= '0;
      drain_cnt      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.wt_rd_en   <= 1'b0;
      bus.wt_rd_addr <= '0;
      bus.load_row   <= '0;
      bus.in_rd_en   <= 1'b0;
      bus.in_rd_addr <= '0;
      bus.row_valid  <= '0;
      bus.out_valid  <= '0;
    end else begin
      // Skew pipelines: load strobe lines up with SRAM data, then row and column skew.
      bus.load_row  <= bus.wt_rd_en ? (ROWS'(1) << bus.wt_rd_addr) : '0;
      bus.row_valid <= {bus.row_valid[ROWS-2:0], bus.in_rd_en};
      bus.out_valid <= {bus.out_valid[COLS-2:0], bus.row_valid[ROWS-1]};

      case (state)
        IDLE: begin
          if (bus.start && (bus.num_vec != '0)) begin
            n_last   <= bus.num_vec - VEC_W'(1);
            bus.busy <= 1'b1;
            if (bus.reuse_weights) begin
              state          <= STREAM;
              bus.in_rd_en   <= 1'b1;
              bus.in_rd_addr <= '0;
            end else begin
              state          <= LOAD_W;
              bus.wt_rd_en   <= 1'b1;
              bus.wt_rd_addr <= '0;
            end
          end
        end
        LOAD_W: begin
          if (bus.wt_rd_addr == AW'(ROWS - 1)) begin
            state        <= WAIT;
            bus.wt_rd_en <= 1'b0;
          end else begin
            bus.wt_rd_addr <= bus.wt_rd_addr + AW'(1);
          end
        end
        WAIT: begin
          state          <= STREAM;
          bus.in_rd_en   <= 1'b1;
          bus.in_rd_addr <= '0;
        end
        STREAM: begin
          if (bus.in_rd_addr == n_last) begin
            state        <= DRAIN;
            bus.in_rd_en <= 1'b0;
            drain_cnt    <= '0;
          end else begin
            bus.in_rd_addr <= bus.in_rd_addr + VEC_W'(1);
          end
        end
        DRAIN: begin
          // Last vector needs ROWS+COLS cycles to leave the bottom of the last column.
          if (drain_cnt == DW'(ROWS + COLS - 1)) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
